// File: rtl/nfc_arbiter.sv
// nfc_arbiter
// Round-robin arbiter in front of a single NAND flash controller. One host
// requester at a time is granted, its command/address is forwarded to the
// controller, and the owner is told when the operation finished, failed or
// timed out. Only one operation is ever outstanding.
module nfc_arbiter #(
    parameter int NumReq        = 4,
    parameter int AddressWidth  = 16,
    parameter int CommandWidth  = 3,
    parameter int TimeoutCycles = 1024
) (
    input  logic                             clk,
    input  logic                             Reset,
    input  logic [NumReq-1:0]                req_valid,
    input  logic [NumReq*CommandWidth-1:0]   req_cmd,
    input  logic [NumReq*AddressWidth-1:0]   req_addr,
    output logic [NumReq-1:0]                req_ready,
    output logic [NumReq-1:0]                req_done,
    output logic [NumReq-1:0]                req_error,
    output logic [CommandWidth-1:0]          nfc_cmd,
    output logic [AddressWidth-1:0]          RWA,
    output logic                             nfc_start,
    input  logic                             nfc_done,
    input  logic                             command_error,
    output logic                             busy,
    output logic [$clog2(NumReq)-1:0]        grant_id,
    output logic                             timeout
);

    localparam int IdW = $clog2(NumReq);

    // Requester count widened by one bit so it can be compared with a raw sum.
    localparam logic [IdW:0] NumWide = (IdW + 1)'(NumReq);

    // Last counter value before the wait is declared lost.
    localparam logic [15:0] TimeoutLast = 16'(TimeoutCycles - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ISSUE    = 2'd1;
    localparam logic [1:0] S_WAIT     = 2'd2;
    localparam logic [1:0] S_COMPLETE = 2'd3;

    // (base + offs) modulo NumReq; both operands are already below NumReq,
    // so a single conditional subtraction is enough.
    function automatic logic [IdW-1:0] wrap_add(input logic [IdW-1:0] base,
                                                input logic [IdW-1:0] offs);
        logic [IdW:0] sum;
        sum = {1'b0, base} + {1'b0, offs};
        sum = (sum >= NumWide) ? (sum - NumWide) : sum;
        return sum[IdW-1:0];
    endfunction

    // One-hot vector with only bit idx set.
    function automatic logic [NumReq-1:0] onehot(input logic [IdW-1:0] idx);
        logic [NumReq-1:0] one;
        one = {{(NumReq - 1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    logic [1:0]              r_state;
    logic [IdW-1:0]          r_rr_ptr;
    logic [IdW-1:0]          r_grant;
    logic [CommandWidth-1:0] r_cmd_q;
    logic [AddressWidth-1:0] r_addr_q;
    logic [15:0]             r_cnt;
    logic [NumReq-1:0]       r_ready;
    logic [NumReq-1:0]       r_done;
    logic [NumReq-1:0]       r_error;
    logic [CommandWidth-1:0] r_nfc_cmd;
    logic [AddressWidth-1:0] r_rwa;
    logic                    r_start;
    logic                    r_busy;
    logic                    r_timeout;

    logic                    w_found;
    logic [IdW-1:0]          w_grant;
    logic                    w_expired;
    logic                    w_err;

    // Round-robin pick: first pending requester at or after the pointer.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (!w_found && req_valid[wrap_add(r_rr_ptr, IdW'(i))]) begin
                w_found = 1'b1;
                w_grant = wrap_add(r_rr_ptr, IdW'(i));
            end else begin
                w_found = w_found;
                w_grant = w_grant;
            end
        end
    end

    // Completion status: a real nfc_done always beats an expiring counter.
    always_comb begin
        w_expired = (r_cnt == TimeoutLast);
        if (nfc_done) begin
            w_err = command_error;
        end else begin
            w_err = 1'b1;
        end
    end

    // Main FSM; every output is a register loaded on the transition into
    // the state in which it must be visible.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_grant   <= '0;
            r_cmd_q   <= '0;
            r_addr_q  <= '0;
            r_cnt     <= 16'd0;
            r_ready   <= '0;
            r_done    <= '0;
            r_error   <= '0;
            r_nfc_cmd <= '0;
            r_rwa     <= '0;
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            // Pulse outputs fall back to zero unless a state re-arms them.
            r_ready <= '0;
            r_done  <= '0;
            r_error <= '0;
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_ready  <= onehot(w_grant);
                        r_cmd_q  <= req_cmd[w_grant*CommandWidth +: CommandWidth];
                        r_addr_q <= req_addr[w_grant*AddressWidth +: AddressWidth];
                        r_grant  <= w_grant;
                        r_busy   <= 1'b1;
                        r_state  <= S_ISSUE;
                    end else begin
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    r_start   <= 1'b1;
                    r_nfc_cmd <= r_cmd_q;
                    r_rwa     <= r_addr_q;
                    r_cnt     <= 16'd0;
                    r_busy    <= 1'b1;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    r_busy <= 1'b1;
                    if (nfc_done || w_expired) begin
                        // r_error is the per-owner copy of the captured error.
                        r_done    <= onehot(r_grant);
                        r_error   <= onehot(r_grant) & {NumReq{w_err}};
                        r_timeout <= r_timeout | !nfc_done;
                        r_state   <= S_COMPLETE;
                    end else begin
                        r_cnt     <= r_cnt + 16'd1;
                        r_state   <= S_WAIT;
                    end
                end
                S_COMPLETE: begin
                    r_rr_ptr <= wrap_add(r_grant, IdW'(1));
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_ready;
    assign req_done  = r_done;
    assign req_error = r_error;
    assign nfc_cmd   = r_nfc_cmd;
    assign RWA       = r_rwa;
    assign nfc_start = r_start;
    assign busy      = r_busy;
    assign grant_id  = r_grant;
    assign timeout   = r_timeout;

endmodule
